// File: rtl/counter_scheduler_pkg.sv
// Shared definitions for the time-shared counter scheduler and its arbiter.
package counter_scheduler_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request scanning upward from pointer+1, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] pointer,
  output logic             valid,
  output logic [PTR_W-1:0] index
);

  logic [PTR_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit is the last to be written.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = {1'b0, pointer} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (req[cand[PTR_W-1:0]]) begin
        valid = 1'b1;
        index = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one up-counter among NREQ requesters: round-robin grant, run len cycles, pulse done.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      count_value
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] len_q, len_nxt;
  logic [PTR_W-1:0] own_q, own_nxt;
  logic [PTR_W-1:0] ptr_q, ptr_nxt;
  logic [NREQ-1:0]  grant_nxt, done_nxt;
  logic             busy_nxt;
  logic [WIDTH-1:0] count_nxt;

  logic             arb_valid;
  logic [PTR_W-1:0] arb_index;
  logic [WIDTH-1:0] len_arr [NREQ];
  logic [WIDTH-1:0] len_sel;

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_arr[i] = len[i*WIDTH +: WIDTH];
  end

  assign len_sel = len_arr[arb_index];

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (req),
    .pointer (ptr_q),
    .valid   (arb_valid),
    .index   (arb_index)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every output is computed here one cycle ahead and registered below.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    done_nxt  = '0;
    busy_nxt  = busy;
    count_nxt = count_value;
    len_nxt   = len_q;
    own_nxt   = own_q;
    ptr_nxt   = ptr_q;
    unique case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        count_nxt = '0;
        if (arb_valid) begin
          own_nxt              = arb_index;
          len_nxt              = len_sel;
          grant_nxt[arb_index] = 1'b1;
          busy_nxt             = 1'b1;
          if (len_sel == '0) begin
            state_nxt           = ST_DONE;
            done_nxt[arb_index] = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Abort still advances the pointer so the aborted owner loses its turn.
        if (abort) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          count_nxt = '0;
          ptr_nxt   = own_q;
        end else if (count_value == len_q - WIDTH'(1)) begin
          state_nxt = ST_DONE;
          done_nxt  = grant;
        end else begin
          count_nxt = count_value + WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        count_nxt = '0;
        ptr_nxt   = own_q;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
      count_value <= '0;
      len_q       <= '0;
      own_q       <= '0;
      ptr_q       <= PTR_W'(NREQ-1);
    end else begin
      grant       <= grant_nxt;
      done        <= done_nxt;
      busy        <= busy_nxt;
      count_value <= count_nxt;
      len_q       <= len_nxt;
      own_q       <= own_nxt;
      ptr_q       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler: directed scenarios plus randomized traffic vs a service model.
module tb_counter_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] len = '0;
  logic                  abort = 1'b0;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      count_value;

  int testsRun = 0;
  int testsFailed = 0;

  // Service-level model: who owns the counter, its interval, and cycles since grant.
  bit mValid = 0;
  bit mActive = 0;
  int mOwner = 0;
  int mLen = 0;
  int mElapsed = 0;
  int mPtr = NREQ - 1;

  counter_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .PTR_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .len         (len),
    .abort       (abort),
    .grant       (grant),
    .busy        (busy),
    .done        (done),
    .count_value (count_value)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
    end
  endtask

  task automatic modelStep();
    bit last;
    bit found;
    int cand;
    if (reset) begin
      mActive = 0;
      mPtr = NREQ - 1;
      mValid = 1;
    end else if (mActive) begin
      last = (mLen == 0) ? (mElapsed == 0) : (mElapsed == mLen);
      if (mLen != 0 && mElapsed < mLen && abort) begin
        mActive = 0;
        mPtr = mOwner;
      end else if (last) begin
        mActive = 0;
        mPtr = mOwner;
      end else begin
        mElapsed++;
      end
    end else if (req != 0) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        cand = (mPtr + k) % NREQ;
        if (!found && req[cand]) begin
          mOwner = cand;
          found = 1;
        end
      end
      mLen = int'(len[mOwner*WIDTH +: WIDTH]);
      mElapsed = 0;
      mActive = 1;
    end
  endtask

  task automatic checkOutput();
    int expGrant, expDone, expBusy, expCount;
    bit last;
    expGrant = 0;
    expDone = 0;
    expBusy = 0;
    expCount = 0;
    if (mActive) begin
      expGrant = 1 << mOwner;
      expBusy = 1;
      last = (mLen == 0) ? (mElapsed == 0) : (mElapsed == mLen);
      expCount = (mLen == 0) ? 0 : ((mElapsed < mLen) ? mElapsed : mLen - 1);
      expDone = last ? expGrant : 0;
    end
    checkVal("model_grant", int'(grant), expGrant);
    checkVal("model_done", int'(done), expDone);
    checkVal("model_busy", int'(busy), expBusy);
    checkVal("model_count", int'(count_value), expCount);
    checkVal("grant_onehot0", $onehot0(grant) ? 1 : 0, 1);
    checkVal("done_within_grant", ((done & ~grant) == '0) ? 1 : 0, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mValid) checkOutput();
    end
  end

  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq, input logic ab);
    @(negedge clk);
    reset = r;
    req = rq;
    abort = ab;
  endtask

  task automatic setLen(input int idx, input int v);
    len[idx*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic waitCount(input int value, input int limit, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (int'(count_value) == value && busy) ok = 1;
    end
    checkVal(name, ok ? 1 : 0, 1);
  endtask

  task automatic waitIdle(input int limit, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      if (!busy && grant == '0) ok = 1;
    end
    checkVal(name, ok ? 1 : 0, 1);
  endtask

  initial begin
    int gExp[5];
    int cExp[5];
    int dExp[5];
    int onsets[$];
    logic [NREQ-1:0] prevGrant;
    int grantCycles, countAtDone, maxCount, cyclesAtDone, doneVal;

    // Single request, len 3, straight after reset.
    setLen(0, 3);
    applyStimulus(1'b1, '0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkVal("reset_grant", int'(grant), 0);
    checkVal("reset_busy", int'(busy), 0);
    checkVal("reset_count", int'(count_value), 0);
    checkVal("reset_done", int'(done), 0);
    gExp = '{1, 1, 1, 1, 0};
    cExp = '{0, 1, 2, 2, 0};
    dExp = '{0, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkVal("single_grant", int'(grant), gExp[i]);
      checkVal("single_count", int'(count_value), cExp[i]);
      checkVal("single_done", int'(done), dExp[i]);
      checkVal("single_busy", int'(busy), gExp[i]);
    end

    // Round-robin with all requesters, len 1.
    for (int i = 0; i < NREQ; i++) setLen(i, 1);
    applyStimulus(1'b1, '0, 1'b0);
    prevGrant = '0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0);
      if (grant != '0 && prevGrant == '0) begin
        for (int b = 0; b < NREQ; b++) if (grant[b]) onsets.push_back(b);
      end
      prevGrant = grant;
    end
    checkVal("rr_onset_count", onsets.size() >= 5 ? 1 : 0, 1);
    gExp = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      checkVal("rr_order", (i < onsets.size()) ? onsets[i] : -1, gExp[i]);
    end
    waitIdle(20, "rr_idle_timeout");

    // Zero-length interval: grant and done share one cycle.
    setLen(2, 0);
    applyStimulus(1'b1, '0, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkVal("zero_grant", int'(grant), 4);
    checkVal("zero_done", int'(done), 4);
    checkVal("zero_count", int'(count_value), 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkVal("zero_after_grant", int'(grant), 0);
    checkVal("zero_after_busy", int'(busy), 0);

    // Abort at count 4, then requester 3 takes the next turn.
    setLen(1, 10);
    setLen(3, 2);
    applyStimulus(1'b1, '0, 1'b0);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    waitCount(4, 30, "abort_wait_timeout");
    abort = 1'b1;
    req = 4'b1010;
    applyStimulus(1'b0, 4'b1010, 1'b0);
    checkVal("abort_grant", int'(grant), 0);
    checkVal("abort_busy", int'(busy), 0);
    checkVal("abort_count", int'(count_value), 0);
    checkVal("abort_done", int'(done), 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkVal("abort_next_owner", int'(grant), 8);
    waitIdle(20, "abort_idle_timeout");

    // Reset while a long interval runs.
    setLen(0, 200);
    applyStimulus(1'b1, '0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    waitCount(50, 80, "midreset_wait_timeout");
    reset = 1'b1;
    req = '0;
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkVal("midreset_grant", int'(grant), 0);
    checkVal("midreset_busy", int'(busy), 0);
    checkVal("midreset_count", int'(count_value), 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkVal("midreset_first_owner", int'(grant), 1);
    waitIdle(260, "midreset_idle_timeout");

    // Maximum length: grant spans 255 RUN cycles plus the DONE cycle.
    setLen(3, 255);
    applyStimulus(1'b1, '0, 1'b0);
    applyStimulus(1'b0, 4'b1000, 1'b0);
    grantCycles = 0;
    countAtDone = -1;
    cyclesAtDone = -1;
    maxCount = 0;
    doneVal = 0;
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'b0, '0, 1'b0);
      if (grant == 4'b1000) begin
        grantCycles++;
        if (int'(count_value) > maxCount) maxCount = int'(count_value);
      end
      if (done != '0) begin
        countAtDone = int'(count_value);
        cyclesAtDone = grantCycles;
        doneVal = int'(done);
      end
      if (grant == '0 && grantCycles > 0) break;
    end
    checkVal("max_grant_cycles_to_done", cyclesAtDone, 256);
    checkVal("max_count_at_done", countAtDone, 254);
    checkVal("max_count_peak", maxCount, 254);
    checkVal("max_done_owner", doneVal, 8);

    // Randomized traffic, checked cycle-by-cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom % 300) == 0, NREQ'($urandom), ($urandom % 12) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (($urandom % 4) == 0) setLen(i, ($urandom % 16 == 0) ? $urandom_range(20, 40) : $urandom_range(0, 6));
      end
    end
    waitIdle(60, "random_idle_timeout");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
